// File: rtl/vigenere_pkg.sv
// Shared character constants, letter test and key FSM state type for the
// Vigenere key-stream feeder and its decryptor.
package vigenere_pkg;

  localparam logic [7:0] NUL_CHAR         = 8'h00;
  localparam logic [7:0] UPPERCASE_A_CHAR = 8'h41;
  localparam logic [7:0] UPPERCASE_Z_CHAR = 8'h5A;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } key_state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= UPPERCASE_A_CHAR) && (c <= UPPERCASE_Z_CHAR);
  endfunction

endpackage

// File: rtl/vigenere_key_stream_if.sv
// Key-load, ciphertext-in and decryptor-facing bundle of vigenere_key_stream.
// Handshake: a ciphertext char moves on a rising edge where ctxt_in_valid && ctxt_in_ready; key chars are taken whenever key_in_valid is high in LOAD.
interface vigenere_key_stream_if #(
  parameter int KEY_MAX_LEN = 16
);
  localparam int LEN_W = $clog2(KEY_MAX_LEN + 1);

  logic             key_load;
  logic [7:0]       key_in;
  logic             key_in_valid;
  logic             key_last;
  logic [7:0]       ctxt_in;
  logic             ctxt_in_valid;
  logic             ctxt_in_ready;
  logic [7:0]       ctx_char;
  logic [7:0]       key_char;
  logic             ctxt_valid;
  logic             key_ok;
  logic             key_err;
  logic [LEN_W-1:0] key_len;

  modport slave (
    input  key_load, key_in, key_in_valid, key_last, ctxt_in, ctxt_in_valid,
    output ctxt_in_ready, ctx_char, key_char, ctxt_valid, key_ok, key_err, key_len
  );

  modport master (
    output key_load, key_in, key_in_valid, key_last, ctxt_in, ctxt_in_valid,
    input  ctxt_in_ready, ctx_char, key_char, ctxt_valid, key_ok, key_err, key_len
  );

endinterface

// File: rtl/vigenere_key_mem.sv
// Key character register file: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module vigenere_key_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vigenere_key_stream.sv
// Stores a key string and pairs each accepted ciphertext char with the next
// key char. Optional macro VIGENERE_SKIP_NONLETTER_EN: key index holds on non-letters.
module vigenere_key_stream
  import vigenere_pkg::*;
#(
  parameter int KEY_MAX_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vigenere_key_stream_if.slave  bus,
  output key_state_t            state_o
);

  localparam int LEN_W = $clog2(KEY_MAX_LEN + 1);
  localparam int IDX_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;

  key_state_t       state_q;
  logic [LEN_W-1:0] wr_ptr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;
  logic             err_q;
  logic [7:0]       ctx_q;
  logic [7:0]       key_q;
  logic             valid_q;

  logic             ready_w;
  logic             key_char_ok;
  logic             mem_we;
  logic [7:0]       mem_rdata;
  logic             idx_adv;

  assign ready_w     = (state_q == READY) && !bus.key_load;
  assign key_char_ok = is_upper(bus.key_in) && (wr_ptr_q != LEN_W'(KEY_MAX_LEN));
  assign mem_we      = (state_q == LOAD) && bus.key_in_valid && !bus.key_load && key_char_ok;

`ifdef VIGENERE_SKIP_NONLETTER_EN
  assign idx_adv = is_upper(bus.ctxt_in);
`else
  assign idx_adv = 1'b1;
`endif

  always_comb begin
    idx_d = idx_q;
    if (idx_adv) begin
      if (idx_q == len_q - LEN_W'(1)) idx_d = '0;
      else                           idx_d = idx_q + LEN_W'(1);
    end
  end

  vigenere_key_mem #(
    .DEPTH (KEY_MAX_LEN),
    .AW    (IDX_W)
  ) u_key_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i (bus.key_in),
    .raddr_i (idx_q[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ctx_q    <= NUL_CHAR;
      key_q    <= NUL_CHAR;
      valid_q  <= 1'b0;
    end else begin
      // Output pair defaults to idle; only a READY handshake overrides it.
      ctx_q   <= NUL_CHAR;
      key_q   <= NUL_CHAR;
      valid_q <= 1'b0;
      if (bus.key_load) begin
        state_q  <= LOAD;
        wr_ptr_q <= '0;
        len_q    <= '0;
        idx_q    <= '0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (bus.key_in_valid) begin
              if (!key_char_ok) begin
                err_q   <= 1'b1;
                state_q <= EMPTY;
                len_q   <= '0;
              end else begin
                wr_ptr_q <= wr_ptr_q + LEN_W'(1);
                if (bus.key_last) begin
                  len_q   <= wr_ptr_q + LEN_W'(1);
                  state_q <= READY;
                end
              end
            end
          end
          READY: begin
            if (bus.ctxt_in_valid) begin
              ctx_q   <= bus.ctxt_in;
              key_q   <= mem_rdata;
              valid_q <= 1'b1;
              idx_q   <= idx_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ctxt_in_ready = ready_w;
  assign bus.ctx_char      = ctx_q;
  assign bus.key_char      = key_q;
  assign bus.ctxt_valid    = valid_q;
  assign bus.key_ok        = (state_q == READY);
  assign bus.key_err       = err_q;
  assign bus.key_len       = len_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_vigenere_key_stream.sv
// Directed bench for vigenere_key_stream with a 4-deep key store; expected
// (ctx,key) pairs are queued when a char is offered and popped on output.
module tb_vigenere_key_stream;
  import vigenere_pkg::*;

  localparam int KML   = 4;
  localparam int LEN_W = $clog2(KML + 1);

  logic       clk;
  logic       rst_n;
  key_state_t dbg_state;
  int         total;
  int         bad;
  logic [15:0] exp_q[$];

  vigenere_key_stream_if #(.KEY_MAX_LEN(KML)) bus ();

  vigenere_key_stream #(.KEY_MAX_LEN(KML)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: pop one expected pair if queued, else expect an idle output
  task automatic check_out(input string tag);
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus.ctxt_valid), 32'd1);
      chk({tag, "_pair"}, {16'd0, bus.ctx_char, bus.key_char}, {16'd0, e});
    end else begin
      chk({tag, "_idle_valid"}, 32'(bus.ctxt_valid), 32'd0);
      chk({tag, "_idle_pair"}, {16'd0, bus.ctx_char, bus.key_char}, 32'd0);
    end
  endtask

  // drivers
  task automatic load_key(input string s, input bit mark_last);
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      bus.key_in       = s[i];
      bus.key_in_valid = 1'b1;
      bus.key_last     = mark_last && (i == s.len() - 1);
      tick();
    end
    bus.key_in_valid = 1'b0;
    bus.key_last     = 1'b0;
    bus.key_in       = 8'h00;
  endtask

  task automatic push_char(input logic [7:0] c, input logic [7:0] k);
    exp_q.push_back({c, k});
    bus.ctxt_in       = c;
    bus.ctxt_in_valid = 1'b1;
    #1;
    chk("ready_on_push", 32'(bus.ctxt_in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.ctxt_in_valid = 1'b0;
    bus.ctxt_in       = 8'h00;
    check_out("stream");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.key_load      = 1'b0;
    bus.key_in        = 8'h00;
    bus.key_in_valid  = 1'b0;
    bus.key_last      = 1'b0;
    bus.ctxt_in       = 8'h00;
    bus.ctxt_in_valid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.ctxt_valid), 32'd0);
    chk("rst_ctx", 32'(bus.ctx_char), 32'd0);
    chk("rst_key", 32'(bus.key_char), 32'd0);
    chk("rst_key_ok", 32'(bus.key_ok), 32'd0);
    chk("rst_key_err", 32'(bus.key_err), 32'd0);
    chk("rst_key_len", 32'(bus.key_len), 32'd0);
    chk("rst_ready", 32'(bus.ctxt_in_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(EMPTY));
    rst_n = 1'b1;
    tick();

    // key "KEY", ciphertext "RIJVS" back to back
    load_key("KEY", 1'b1);
    chk("key_ok_KEY", 32'(bus.key_ok), 32'd1);
    chk("key_len_KEY", 32'(bus.key_len), 32'd3);
    chk("key_err_KEY", 32'(bus.key_err), 32'd0);
    push_char("R", "K");
    push_char("I", "E");
    push_char("J", "Y");
    push_char("V", "K");
    push_char("S", "E");
    tick();
    check_out("after_RIJVS");

    // key "AB", ciphertext "C C"
    load_key("AB", 1'b1);
    push_char("C", "A");
    push_char(8'h20, "B");
`ifdef VIGENERE_SKIP_NONLETTER_EN
    push_char("C", "B");
`else
    push_char("C", "A");
`endif

    // illegal key character
    load_key("AB1", 1'b1);
    bus.ctxt_in_valid = 1'b1;
    bus.ctxt_in       = "Q";
    #1;
    chk("bad_key_err", 32'(bus.key_err), 32'd1);
    chk("bad_key_ok", 32'(bus.key_ok), 32'd0);
    chk("bad_key_len", 32'(bus.key_len), 32'd0);
    chk("bad_key_ready", 32'(bus.ctxt_in_ready), 32'd0);
    tick();
    bus.ctxt_in_valid = 1'b0;
    check_out("bad_key_no_out");
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    chk("reload_clears_err", 32'(bus.key_err), 32'd0);
    chk("reload_state", 32'(dbg_state), 32'(LOAD));

    // overflow and full-length key
    load_key("ABCDE", 1'b1);
    chk("ovf_err", 32'(bus.key_err), 32'd1);
    chk("ovf_len", 32'(bus.key_len), 32'd0);
    chk("ovf_ok", 32'(bus.key_ok), 32'd0);
    load_key("ABCD", 1'b1);
    chk("full_ok", 32'(bus.key_ok), 32'd1);
    chk("full_len", 32'(bus.key_len), 32'd4);
    chk("full_err", 32'(bus.key_err), 32'd0);
    push_char("W", "A");
    push_char("X", "B");
    push_char("Y", "C");
    push_char("Z", "D");
    push_char("W", "A");

    // key_load colliding with an offered char
    load_key("KEY", 1'b1);
    push_char("R", "K");
    bus.key_load      = 1'b1;
    bus.ctxt_in_valid = 1'b1;
    bus.ctxt_in       = "I";
    #1;
    chk("collide_ready", 32'(bus.ctxt_in_ready), 32'd0);
    tick();
    bus.key_load      = 1'b0;
    bus.ctxt_in_valid = 1'b0;
    check_out("collide_no_out");
    load_key("Z", 1'b1);
    chk("len1_len", 32'(bus.key_len), 32'd1);
    for (int i = 0; i < 4; i++) begin
      push_char(8'($urandom_range(32'h41, 32'h5A)), "Z");
    end

    // asynchronous reset mid-stream
    bus.ctxt_in       = "Q";
    bus.ctxt_in_valid = 1'b1;
    tick();
    bus.ctxt_in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.ctxt_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ctxt_valid), 32'd0);
    chk("arst_ctx", 32'(bus.ctx_char), 32'd0);
    chk("arst_key", 32'(bus.key_char), 32'd0);
    chk("arst_key_ok", 32'(bus.key_ok), 32'd0);
    chk("arst_key_len", 32'(bus.key_len), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(EMPTY));
    #2;
    rst_n = 1'b1;
    tick();
    bus.ctxt_in       = "Q";
    bus.ctxt_in_valid = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.ctxt_in_ready), 32'd0);
    tick();
    bus.ctxt_in_valid = 1'b0;
    check_out("post_rst_no_out");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vigenere_key_stream.md
# vigenere_key_stream

Upstream feeder for the Vigenère decryption stage. Stores a key string of up to `KEY_MAX_LEN` uppercase letters and accepts a stream of ciphertext characters. For each accepted character it presents a registered `ctx_char`/`key_char`/`ctxt_valid` triple, cycling through the stored key with wrap-around. Its outputs connect one-to-one to the decryptor's `ctx_char`, `key_char` and `ctxt_valid` inputs.

## Interface
- `KEY_MAX_LEN`, default 16: key storage depth in characters; must be ≥ 1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_load`  in  1: one-cycle pulse; starts a new key load and aborts any current activity.
- `key_in`  in  8: key character (ASCII).
- `key_in_valid`  in  1: `key_in` is valid this cycle (honoured only in LOAD).
- `key_last`  in  1: qualifies `key_in_valid`; marks the final key character.
- `ctxt_in`  in  8: ciphertext character (ASCII).
- `ctxt_in_valid`  in  1: `ctxt_in` is offered.
- `ctxt_in_ready`  out  1: combinational, `(state == READY) && !key_load`.
- `ctx_char`  out  8: registered ciphertext character to the decryptor.
- `key_char`  out  8: registered key character to the decryptor.
- `ctxt_valid`  out  1: registered; the pair is valid.
- `key_ok`  out  1: a valid key is stored (state READY).
- `key_err`  out  1: sticky load error; cleared by `key_load`.
- `key_len`  out  `$clog2(KEY_MAX_LEN+1)`: stored key length.

## Operation
- FSM states:
  - EMPTY: reset state; no key stored.
  - LOAD: key characters being written.
  - READY: key stored; ciphertext is accepted.
- `key_load` in any state moves to LOAD next cycle and clears write pointer, `key_len`, read index and `key_err`. `key_load` has priority over every other input.
- LOAD, on each `key_in_valid`:
  - If `key_in` is outside 0x41..0x5A ('A'..'Z'): set `key_err`, go to EMPTY, set `key_len` = 0.
  - Else if the write pointer equals `KEY_MAX_LEN` (overflow): set `key_err`, go to EMPTY, set `key_len` = 0.
  - Else store the character at the write pointer and increment it. If `key_last`, set `key_len` to the pointer value plus 1 and go to READY.
- READY, on a handshake (`ctxt_in_valid && ctxt_in_ready`):
  - Next cycle: `ctx_char` = `ctxt_in`, `key_char` = key[idx], `ctxt_valid` = 1.
  - idx advances per Configuration. It wraps from `key_len`−1 to 0.
- No handshake: next cycle `ctxt_valid` = 0 and `ctx_char` = `key_char` = 0x00.
- Non-letter ciphertext passes through unchanged. The decryptor is responsible for dropping it.
- No back-pressure from downstream: the decryptor accepts one character per cycle.

## Timing
- Reset values: `ctx_char` = 0x00, `key_char` = 0x00, `ctxt_valid` = 0, `key_ok` = 0, `key_err` = 0, `key_len` = 0, state EMPTY, idx = 0.
- Latency: 1 cycle from handshake to `ctxt_valid`.
- Throughput: 1 character per cycle in READY.
- First ciphertext can be accepted the cycle after the `key_last` write (READY is registered).
- `key_load` in the same cycle as `ctxt_in_valid` in READY: `ctxt_in_ready` = 0 and the character is not accepted. `ctxt_valid` is 0 the next cycle.
- `key_load` while in LOAD restarts the load. Partial key data is discarded.
- Key storage contents are not reset. Only `key_len` and the pointers are reset.
- Key length 1: idx stays at 0.
- Key length `KEY_MAX_LEN`: the last write with `key_last` succeeds. Any further write without `key_last` sets `key_err`.

## Configuration
- `VIGENERE_SKIP_NONLETTER_EN`:
  - Defined: idx advances only when the accepted `ctxt_in` is in 'A'..'Z'. A non-letter is presented with the current key char and idx holds.
  - Undefined: idx advances on every accepted character.

## Structure
- Shared package `vigenere_pkg` holds:
  - Constants `NUL_CHAR`, `UPPERCASE_A_CHAR`, `UPPERCASE_Z_CHAR`.
  - Function `is_upper(logic [7:0])`.
  - Enum `key_state_t` {EMPTY, LOAD, READY}.
- Sub-module `vigenere_key_mem`: `KEY_MAX_LEN`×8 register file with one synchronous write port and one combinational read port. The FSM, pointers and output registers stay in the top level.

## Test plan
- Load key "KEY" (0x4B, 0x45, 0x59, last on 0x59), stream "RIJVS" back to back. Required pairs: (R,K), (I,E), (J,Y), (V,K), (S,E), each 1 cycle after acceptance. Chained decryptor outputs "HELLO".
- With `VIGENERE_SKIP_NONLETTER_EN`, key "AB", stream "C C". Required pairs: (C,A), (' ',B), (C,B). Without the macro: (C,A), (' ',B), (C,A).
- Load "AB1": `key_err` = 1, `key_ok` = 0, `key_len` = 0, `ctxt_in_ready` = 0. A subsequent `key_load` clears `key_err`.
- With `KEY_MAX_LEN` = 4, load "ABCDE" with last on 'E': `key_err` = 1. Loading "ABCD" with last on 'D' gives `key_ok` = 1 and `key_len` = 4.
- During a streaming run, pulse `key_load` together with `ctxt_in_valid`: the character is not accepted and `ctxt_valid` = 0 next cycle. After reloading "Z", every pair carries 'Z'.
- Assert `rst_n` low mid-stream: all outputs return asynchronously to reset values. After release, `ctxt_in_ready` = 0 until a new key is loaded.
